// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS main controller (master) and the datapath (slave).
// Carries the opcode/flag inputs to the FSM and every enable/select it drives back.
interface mips_multicycle_ctrl_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         opcode;
   logic               zero;
   logic               mem_ready;
   logic               ir_write;
   logic               pc_en;
   logic               i_or_d;
   logic               mem_write;
   logic               reg_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_src;
   logic               illegal_op;
   logic [STATE_W-1:0] dbg_state;

   modport master (
      input  opcode, zero, mem_ready,
      output ir_write, pc_en, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, dbg_state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  ir_write, pc_en, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, dbg_state
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Optional macro MIPS_CTRL_MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until mem_ready is sampled high.
module mips_multicycle_ctrl #(
   parameter bit ADDI_EN = 1'b1,
   parameter int STATE_W = 4
) (
   input logic                    clk,
   input logic                    reset_n,
   mips_multicycle_ctrl_if.master bus
);
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic [3:0] state;
   logic [3:0] state_nx;
   logic       op_legal;
   logic       mem_done;
   logic       pc_write;
   logic       branch;

`ifdef MIPS_CTRL_MEM_WAIT_EN
   assign mem_done = bus.mem_ready;
`else
   assign mem_done = 1'b1;
`endif

   always_comb begin
      case (bus.opcode)
         OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: op_legal = 1'b1;
         OP_ADDI:                              op_legal = ADDI_EN;
         default:                              op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = S_FETCH;
      case (state)
         S_FETCH:   state_nx = mem_done ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (op_legal) begin
               case (bus.opcode)
                  OP_LW, OP_SW: state_nx = S_MEMADR;
                  OP_RTYPE:     state_nx = S_EXECUTE;
                  OP_BEQ:       state_nx = S_BRANCH;
                  OP_ADDI:      state_nx = S_ADDIEX;
                  OP_J:         state_nx = S_JUMP;
                  default:      state_nx = S_FETCH;
               endcase
            end
         end
         S_MEMADR:  state_nx = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_nx = mem_done ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_nx = mem_done ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_nx = S_ALUWB;
         S_ADDIEX:  state_nx = S_ADDIWB;
         default:   state_nx = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!reset_n) state <= S_FETCH;
      else          state <= state_nx;
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
      bus.ir_write   = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 2'b00;
      bus.pc_src     = 2'b00;
      bus.illegal_op = 1'b0;
      pc_write       = 1'b0;
      branch         = 1'b0;
      // Gating on reset_n drops the write strobes in the very cycle reset falls.
      if (reset_n) begin
         case (state)
            S_FETCH: begin
               bus.ir_write  = mem_done;
               pc_write      = mem_done;
               bus.alu_src_b = 2'b01;
            end
            S_DECODE: begin
               bus.alu_src_b  = 2'b11;
               bus.illegal_op = ~op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
            end
            S_MEMRD: bus.i_or_d = 1'b1;
            S_MEMWB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               bus.i_or_d    = 1'b1;
               bus.mem_write = 1'b1;
            end
            S_EXECUTE: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b10;
            end
            S_ALUWB: begin
               bus.reg_dst   = 1'b1;
               bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b01;
               bus.pc_src    = 2'b01;
               branch        = 1'b1;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JUMP: begin
               bus.pc_src = 2'b10;
               pc_write   = 1'b1;
            end
            default: ;
         endcase
      end
      bus.pc_en = pc_write | (branch & bus.zero);
   end

   assign bus.dbg_state = STATE_W'(state);
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALU source-B select of the operand-B 4:1 mux, plus all other datapath enables and selects.
- Consumes the opcode from the instruction register and the ALU zero flag.

Parameters:
- ADDI_EN, 1, when 1 the addi opcode (6'h08) is decoded; when 0 it is treated as illegal.
- STATE_W, 4, width of the debug state output.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access complete; used only with the optional feature.
- ir_write  output  1  load the instruction register.
- pc_en  output  1  PC load enable, equal to pc_write | (branch & zero).
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  destination register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  writeback data select: 0 = ALUOut, 1 = memory data.
- alu_src_a  output  1  ALU operand A select: 0 = PC, 1 = register A.
- alu_src_b  output  2  operand-B mux select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  output  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct field.
- pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  one-cycle pulse on an undecoded opcode.
- dbg_state  output  STATE_W  current state encoding.

Behaviour:
- Reset (asynchronous, active-low):
  - State register goes to FETCH.
  - While reset_n = 0, every enable is forced to 0: ir_write, pc_en, mem_write, reg_write, illegal_op.
  - All selects read 0, except dbg_state, which reads the FETCH encoding (0).
  - Operation starts on the first rising edge after reset_n deasserts.
- Outputs are Moore: decoded combinationally from the current state only. zero and mem_ready affect outputs only through pc_en and the next-state logic.
- Default value of every output not listed below is 0.
- States, their outputs, and transitions:
  - FETCH (0): ir_write = 1, alu_src_b = 01, pc_write = 1. Next: DECODE.
  - DECODE (1): alu_src_b = 11 (precomputes the branch target). Next state by opcode:
    - 6'h23 (lw) or 6'h2B (sw) -> MEMADR
    - 6'h00 (R-type) -> EXECUTE
    - 6'h04 (beq) -> BRANCH
    - 6'h08 (addi, when ADDI_EN = 1) -> ADDIEX
    - 6'h02 (j) -> JUMP
    - any other opcode -> FETCH with illegal_op = 1 for that cycle
  - MEMADR (2): alu_src_a = 1, alu_src_b = 10. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD (3): i_or_d = 1. Next: MEMWB.
  - MEMWB (4): reg_write = 1, mem_to_reg = 1. Next: FETCH.
  - MEMWR (5): i_or_d = 1, mem_write = 1. Next: FETCH.
  - EXECUTE (6): alu_src_a = 1, alu_op = 10. Next: ALUWB.
  - ALUWB (7): reg_dst = 1, reg_write = 1. Next: FETCH.
  - BRANCH (8): alu_src_a = 1, alu_op = 01, pc_src = 01, branch = 1. Next: FETCH.
  - ADDIEX (9): alu_src_a = 1, alu_src_b = 10. Next: ADDIWB.
  - ADDIWB (10): reg_write = 1. Next: FETCH.
  - JUMP (11): pc_src = 10, pc_write = 1. Next: FETCH.
- Unused encodings (12-15) transition to FETCH, with all outputs at default.
- Opcode is sampled only in DECODE and MEMADR. Changes at any other time are ignored.
- Instruction latency: lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2 (FETCH, DECODE).
- Reset asserted mid-instruction: the in-flight instruction is aborted with no write. mem_write and reg_write drop in the same cycle reset_n falls.

Optional Feature:
- Macro: MIPS_CTRL_MEM_WAIT_EN.
- Defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready = 1 is sampled.
  - In FETCH, pc_write and ir_write are asserted only in the cycle mem_ready = 1.
  - mem_write stays high for the whole MEMWR wait.
- Undefined: mem_ready is ignored; every state lasts exactly one cycle as listed above.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles -> dbg_state = 0 and all enables = 0. After release: cycle 1 shows ir_write = 1, pc_en = 1, alu_src_b = 01.
- lw (opcode 6'h23) -> dbg_state sequence 0, 1, 2, 3, 4, 0. alu_src_b = 10 in MEMADR. reg_write = 1 and mem_to_reg = 1 only in MEMWB.
- beq (6'h04):
  - zero = 1 -> pc_en = 1 in BRANCH, with pc_src = 01 and alu_op = 01.
  - zero = 0 -> pc_en = 0 in BRANCH.
- R-type (6'h00) then j (6'h02) back to back -> states 0, 1, 6, 7, 0, 1, 11, 0. pc_src = 10 in JUMP.
- Opcode 6'h3F -> illegal_op pulses for exactly 1 cycle in DECODE, then FETCH. With ADDI_EN = 0, opcode 6'h08 behaves the same way.
- With MIPS_CTRL_MEM_WAIT_EN: sw with mem_ready low for 3 cycles -> MEMWR lasts 4 cycles with mem_write = 1 throughout. Assert reset_n = 0 during the wait -> mem_write = 0 immediately.
